// File: rtl/addr_decoding_prog.sv
// Program-memory window decoder: CS_P/offset are combinational; cs_p_q, offset_q, oob_err, hit_cnt are registered (1 cycle).
// No backpressure: every cycle's addr/addr_valid is consumed, hit_cnt saturates instead of wrapping.
module addr_decoding_prog #(
    parameter int                ADDR_W = 32,
    parameter logic [ADDR_W-1:0] INF    = 32'h0000_09F0,
    parameter logic [ADDR_W-1:0] SUP    = 32'h0000_1A13,
    parameter int                OFS_W  = 13,
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              addr_valid,
    input  logic              err_clr,
    output logic              CS_P,
    output logic              cs_p_q,
    output logic [OFS_W-1:0]  offset,
    output logic [OFS_W-1:0]  offset_q,
    output logic              oob_err,
    output logic [CNT_W-1:0]  hit_cnt
);

    localparam longint unsigned SPAN = 64'(SUP) - 64'(INF);

    generate
        if ((INF > SUP) || (SPAN >= (64'd1 << OFS_W))) begin : g_bad_window
            $error("addr_decoding_prog: window [INF,SUP] empty or wider than offset field");
        end
    endgenerate

    logic [OFS_W-1:0] rel;

    // Offset is only meaningful inside the window, so the truncated difference never aliases.
    assign CS_P   = (addr >= INF) && (addr <= SUP);
    assign rel    = OFS_W'(addr - INF);
    assign offset = CS_P ? rel : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_p_q   <= 1'b0;
            offset_q <= '0;
            oob_err  <= 1'b0;
            hit_cnt  <= '0;
        end else begin
            cs_p_q   <= CS_P & addr_valid;
            offset_q <= addr_valid ? offset : '0;
            if (err_clr) begin
                oob_err <= 1'b0;
                hit_cnt <= '0;
            end else if (addr_valid && !CS_P) begin
                oob_err <= 1'b1;
            end else if (addr_valid && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_addr_decoding_prog.sv
// Scoreboarded bench: driver pushes expected registered state per cycle, monitor pops after each rising edge.
module tb_addr_decoding_prog;

    localparam longint INF_I = 64'h09F0;
    localparam longint SUP_I = 64'h1A13;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic        addr_valid = 1'b0;
    logic        err_clr = 1'b0;

    logic        CS_P, cs_p_q, oob_err;
    logic [12:0] offset, offset_q;
    logic [15:0] hit_cnt;
    logic        CS_P4, cs_p_q4, oob_err4;
    logic [12:0] offset4, offset_q4;
    logic [3:0]  hit_cnt4;

    addr_decoding_prog u_dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .addr_valid(addr_valid), .err_clr(err_clr),
        .CS_P(CS_P), .cs_p_q(cs_p_q), .offset(offset), .offset_q(offset_q),
        .oob_err(oob_err), .hit_cnt(hit_cnt)
    );

    addr_decoding_prog #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .addr_valid(addr_valid), .err_clr(err_clr),
        .CS_P(CS_P4), .cs_p_q(cs_p_q4), .offset(offset4), .offset_q(offset_q4),
        .oob_err(oob_err4), .hit_cnt(hit_cnt4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cs;
        logic [12:0] ofs;
        logic        err;
        logic [15:0] h16;
        logic [3:0]  h4;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   m_err = 0;
    int   m_hits = 0;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit m_in(input logic [31:0] a);
        return (longint'(a) >= INF_I) && (longint'(a) <= SUP_I);
    endfunction

    function automatic longint m_ofs(input logic [31:0] a);
        return m_in(a) ? (longint'(a) - INF_I) : 64'd0;
    endfunction

    function automatic int sat(input int n, input int max);
        return (n > max) ? max : n;
    endfunction

    // Applies one cycle of stimulus, checks the combinational outputs, queues the post-edge expectation.
    task automatic drive(input logic [31:0] a, input logic v, input logic c);
        exp_t e;
        @(negedge clk);
        addr = a; addr_valid = v; err_clr = c;
        #1;
        chk("cs_p", CS_P, m_in(a));
        chk("offset", offset, m_ofs(a));
        chk("cs_p_w4", CS_P4, m_in(a));
        if (c) begin
            m_err = 0; m_hits = 0;
        end else if (v && !m_in(a)) begin
            m_err = 1;
        end else if (v) begin
            m_hits++;
        end
        e.cs  = v && m_in(a);
        e.ofs = v ? 13'(m_ofs(a)) : 13'd0;
        e.err = m_err;
        e.h16 = 16'(sat(m_hits, 65535));
        e.h4  = 4'(sat(m_hits, 15));
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cs_p_q", cs_p_q, e.cs);
                chk("offset_q", offset_q, e.ofs);
                chk("oob_err", oob_err, e.err);
                chk("hit_cnt", hit_cnt, e.h16);
                chk("hit_cnt_w4", hit_cnt4, e.h4);
                chk("oob_err_w4", oob_err4, e.err);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_cs_p_q"}, cs_p_q, 0);
        chk({tag, "_offset_q"}, offset_q, 0);
        chk({tag, "_oob_err"}, oob_err, 0);
        chk({tag, "_hit_cnt"}, hit_cnt, 0);
        chk({tag, "_hit_cnt_w4"}, hit_cnt4, 0);
    endtask

    logic [31:0] comb_tab [10];
    logic [31:0] ra;

    initial begin : stim
        comb_tab = '{32'h08F0, 32'h09F0, 32'h1000, 32'h1A13, 32'h1A14,
                     32'h09EF, 32'h1234, 32'hFFFF_FFFF, 32'h0, 32'h0000_19FF};
        #2;
        check_reset_state("rst");
        // Combinational window with reset held, registers frozen.
        foreach (comb_tab[i]) begin
            addr = comb_tab[i];
            #10;
            chk("comb_cs_p", CS_P, m_in(comb_tab[i]));
            chk("comb_offset", offset, m_ofs(comb_tab[i]));
        end
        @(negedge clk);
        rst_n = 1'b1;

        drive(32'h1000, 1, 0);
        drive(32'h1000, 0, 0);
        drive(32'h09F0, 1, 0);
        drive(32'h1A13, 1, 0);
        drive(32'h1234, 1, 0);
        drive(32'h1A14, 1, 0);
        drive(32'h1A14, 1, 1);
        drive(32'h09EF, 1, 0);
        drive(32'h09EF, 0, 1);

        for (int i = 0; i < 20; i++) drive(32'h09F0 + 32'(i * 7), 1, 0);
        drive(32'h1000, 0, 0);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: ra = $urandom;
                1: ra = 32'(INF_I) + $urandom_range(0, 8) - 32'd4;
                2: ra = 32'(SUP_I) + $urandom_range(0, 8) - 32'd4;
                default: ra = 32'(INF_I) + $urandom_range(0, 32'h1023);
            endcase
            drive(ra, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end

        drive(32'h1000, 0, 1);
        for (int i = 0; i < 5; i++) drive(32'h1100, 1, 0);
        drive(32'h0000_0010, 1, 0);

        // Asynchronous reset between edges, after the monitor has consumed the last expectation.
        @(posedge clk);
        #3;
        addr_valid = 1'b0; err_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_state("arst");
        m_err = 0; m_hits = 0;
        addr = 32'h1000;
        #10;
        chk("arst_cs_p", CS_P, 1);
        chk("arst_offset", offset, 13'h0610);
        addr = 32'h1A14;
        #10;
        chk("arst_cs_p_out", CS_P, 0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(32'h1A13, 1, 0);
        drive(32'h0, 1, 0);
        drive(32'h1000, 0, 0);

        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
